// File: rtl/glip_seq_checker.sv
// glip_seq_checker: checks that the host-to-device FX2 stream is an incrementing
// WIDTH-bit sequence. It counts words and mismatches, and loops every word back
// unchanged through a 2-entry FIFO toward the device-to-host side.
module glip_seq_checker #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 locked,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [WIDTH-1:0]     err_expected,
  output logic [WIDTH-1:0]     err_received
);

  typedef enum logic {
    ST_UNSYNC = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic [WIDTH-1:0] expected;
  logic             accept;
  logic             emit;
  logic             mismatch;

  assign accept   = in_valid & in_ready;
  assign emit     = out_valid & out_ready;
  assign out_data = mem[rd_ptr];
  assign locked   = (state == ST_LOCKED);
  assign mismatch = (state == ST_LOCKED) && (in_data != expected);

  // Next buffer occupancy: accept and emit in the same cycle cancel out.
  always_comb begin
    occ_next = occ;
    unique case ({accept, emit})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // FIFO storage and pointers; in_ready/out_valid are registered from occ_next
  // so that out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
    end else begin
      occ       <= occ_next;
      in_ready  <= (occ_next < 2'd2);
      out_valid <= (occ_next != 2'd0);
      if (accept) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (emit) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Checker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_UNSYNC;
    end else begin
      state <= state_next;
    end
  end

  // Clear always returns to UNSYNC; any counted word leaves the checker locked.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_UNSYNC;
    end else if (accept) begin
      state_next = ST_LOCKED;
    end
  end

  // Counters, sticky flag and first-mismatch capture. The expected value is
  // always the received word plus one: on a match that equals expected+1, and
  // on a mismatch it resynchronises so one dropped word costs one error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected     <= '0;
      word_count   <= '0;
      error_count  <= '0;
      error        <= 1'b0;
      err_expected <= '0;
      err_received <= '0;
    end else if (clear) begin
      word_count   <= '0;
      error_count  <= '0;
      error        <= 1'b0;
      err_expected <= '0;
      err_received <= '0;
    end else if (accept) begin
      expected <= in_data + WIDTH'(1);
      if (word_count != '1) begin
        word_count <= word_count + CNT_WIDTH'(1);
      end
      if (mismatch) begin
        error <= 1'b1;
        if (error_count != '1) begin
          error_count <= error_count + CNT_WIDTH'(1);
        end
        if (!error) begin
          err_expected <= expected;
          err_received <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_glip_seq_checker.sv
// Scoreboard bench for glip_seq_checker: the driver pushes every accepted word,
// a monitor checks the buffer head, occupancy-derived handshakes and pops on emit.
module tb_glip_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        locked;
  logic        error;
  logic [31:0] word_count;
  logic [31:0] error_count;
  logic [15:0] err_expected;
  logic [15:0] err_received;

  logic [15:0] sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          occ      = 0;
  int          ready_mode = 0;

  glip_seq_checker #(.WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .locked       (locked),
    .error        (error),
    .word_count   (word_count),
    .error_count  (error_count),
    .err_expected (err_expected),
    .err_received (err_received)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expect_v);
    checks++;
    if (actual !== expect_v) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expect_v, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one word from posedge+1, hold it until accepted, push it to the scoreboard.
  task automatic applyStimulus(input logic [15:0] data);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = data;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(data);
        break;
      end
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout: word 0x%0h not accepted, expected acceptance", data);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    waitCycles(1);
    clear = 1'b0;
  endtask

  // Downstream ready pattern: always ready, ~30% random, or fully stalled.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       out_ready = ($urandom_range(0, 99) < 30);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: head entry, occupancy-derived valid/ready, pop on emit.
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
    end else begin
      checkOutput("out_valid_vs_occupancy", {31'd0, out_valid}, {31'd0, occ != 0});
      if (occ == 2) begin
        checkOutput("in_ready_when_full", {31'd0, in_ready}, 32'd0);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL out_unexpected: got 0x%0h, expected no word", out_data);
        end else begin
          checkOutput("out_data", {16'd0, out_data}, {16'd0, sb[0]});
          if (out_ready) begin
            void'(sb.pop_front());
          end
        end
      end
      occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (sb.size() != 0 && n < 500) begin
      waitCycles(1);
      n++;
    end
    checkOutput("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b1;

    // Reset values, then in_ready rises one edge after release.
    #3;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", {16'd0, out_data}, 32'd0);
    checkOutput("rst_word_count", word_count, 32'd0);
    checkOutput("rst_locked", {31'd0, locked}, 32'd0);
    #9 rst_n = 1'b1;
    #1 checkOutput("pre_edge_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic incrementing sequence.
    $display("[TB] basic sequence");
    for (int i = 0; i < 256; i++) applyStimulus(16'h0005 + 16'(i));
    drain();
    checkOutput("basic_word_count", word_count, 32'd256);
    checkOutput("basic_error_count", error_count, 32'd0);
    checkOutput("basic_locked", {31'd0, locked}, 32'd1);
    checkOutput("basic_error", {31'd0, error}, 32'd0);

    // Wrap of the expected value is not an error.
    $display("[TB] wrap");
    pulseClear();
    applyStimulus(16'hFFFE);
    applyStimulus(16'hFFFF);
    applyStimulus(16'h0000);
    applyStimulus(16'h0001);
    drain();
    checkOutput("wrap_error_count", error_count, 32'd0);
    checkOutput("wrap_word_count", word_count, 32'd4);

    // Dropped word, then a second mismatch that must not overwrite the capture.
    $display("[TB] dropped word");
    pulseClear();
    applyStimulus(16'h0010);
    applyStimulus(16'h0011);
    applyStimulus(16'h0013);
    applyStimulus(16'h0014);
    drain();
    checkOutput("drop_error_count", error_count, 32'd1);
    checkOutput("drop_err_expected", {16'd0, err_expected}, 32'h0012);
    checkOutput("drop_err_received", {16'd0, err_received}, 32'h0013);
    checkOutput("drop_error", {31'd0, error}, 32'd1);
    checkOutput("drop_word_count", word_count, 32'd4);
    applyStimulus(16'h0020);
    drain();
    checkOutput("drop2_error_count", error_count, 32'd2);
    checkOutput("drop2_err_expected", {16'd0, err_expected}, 32'h0012);
    checkOutput("drop2_err_received", {16'd0, err_received}, 32'h0013);

    // Random backpressure with continuous input.
    $display("[TB] backpressure");
    pulseClear();
    ready_mode = 1;
    for (int i = 0; i < 1000; i++) applyStimulus(16'h1000 + 16'(i));
    idle();
    ready_mode = 0;
    drain();
    checkOutput("bp_word_count", word_count, 32'd1000);
    checkOutput("bp_error_count", error_count, 32'd0);

    // Clear in the same cycle as an accept: forwarded but not counted.
    $display("[TB] clear with accept");
    clear = 1'b1;
    applyStimulus(16'h0100);
    clear = 1'b0;
    idle();
    checkOutput("clr_word_count", word_count, 32'd0);
    checkOutput("clr_locked", {31'd0, locked}, 32'd0);
    applyStimulus(16'h0200);
    idle();
    checkOutput("clr_relock", {31'd0, locked}, 32'd1);
    checkOutput("clr_word_count2", word_count, 32'd1);
    checkOutput("clr_error", {31'd0, error}, 32'd0);
    drain();

    // Asynchronous reset with two words stalled in the buffer.
    $display("[TB] reset mid-stream");
    ready_mode = 2;
    waitCycles(1);
    applyStimulus(16'h0300);
    applyStimulus(16'h0301);
    idle();
    waitCycles(1);
    checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("full_out_data", {16'd0, out_data}, 32'h0300);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("arst_word_count", word_count, 32'd0);
    checkOutput("arst_locked", {31'd0, locked}, 32'd0);
    checkOutput("arst_error_count", error_count, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    ready_mode = 0;
    checkOutput("arst_release_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("arst_edge_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(16'h0400);
    drain();
    checkOutput("arst_after_word_count", word_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
